pipe_stall_ctrl: RTL

- Hazard and stall sequencer for the 5-stage pipeline.
- Generates the write-enables for the F-stage PC and the D-stage pipeline register, plus the synchronous clear for the E-stage register.
- Combines Tuse/Tnew data-hazard detection with a cycle-accurate busy tracker for the multiply/divide unit.
- Sits beside the datapath; its outputs drive the WE input of the D pipeline register and the clear input of the E pipeline register.

---
 rtl/pipe_stall_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: Tuse/Tnew data hazards plus MD busy tracking.
// Optional macro STALL_CNT_EN adds a saturating 32-bit stall cycle counter on stall_cnt.
module pipe_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_dst,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        F_WE,
  output logic        D_WE,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             stall_rs_s, stall_rt_s, stall_md_s, stall_s;

  // Data-hazard detection; $0 is never a real dependency
  always_comb begin
    stall_rs_s = 1'b0;
    stall_rt_s = 1'b0;
    if (D_rs != 5'd0) begin
      stall_rs_s = ((D_rs == E_dst) && (D_Tuse_rs < E_Tnew)) ||
                   ((D_rs == M_dst) && (D_Tuse_rs < M_Tnew));
    end else begin
      stall_rs_s = 1'b0;
    end
    if (D_rt != 5'd0) begin
      stall_rt_s = ((D_rt == E_dst) && (D_Tuse_rt < E_Tnew)) ||
                   ((D_rt == M_dst) && (D_Tuse_rt < M_Tnew));
    end else begin
      stall_rt_s = 1'b0;
    end
  end

  assign md_busy    = (md_cnt_q != CNT_ZERO);
  assign stall_md_s = D_is_md & (md_busy | E_md_start);
  assign stall_s    = stall_rs_s | stall_rt_s | stall_md_s;

  assign F_WE  = ~stall_s;
  assign D_WE  = ~stall_s;
  assign E_clr = stall_s;

  // MD busy countdown: a start (even while busy) reloads, stalls never freeze it
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_md_start) begin
      md_cnt_d = E_md_is_div ? DIV_CNT : MULT_CNT;
    end else if (md_cnt_q != CNT_ZERO) begin
      md_cnt_d = md_cnt_q - CNT_ONE;
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // MD counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= CNT_ZERO;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
